// File: rtl/pulse_adc_demod.sv
// Dithered-pulse ADC demodulator: averages adc_a over the plus and minus phases of P and reports j_plus/j_minus/dj.
// Latency: valid 3 adc_clk edges after the first edge sampling P high (two-flop sync + FSM register).
// Backpressure: none; valid is a one-cycle strobe, a short or aborted phase raises sticky err instead.
module pulse_adc_demod #(
    parameter int ADC_WIDTH     = 14,
    parameter int SETTLE_CYCLES = 16,
    parameter int AVG_LOG2      = 8
) (
    input  logic                 adc_clk,
    input  logic                 adc_rstn,
    input  logic                 P,
    input  logic [ADC_WIDTH-1:0] adc_a,
    input  logic                 clr_err,
    output logic [ADC_WIDTH-1:0] j_plus,
    output logic [ADC_WIDTH-1:0] j_minus,
    output logic [ADC_WIDTH:0]   dj,
    output logic                 valid,
    output logic                 err
);

    localparam int              ACC_W       = ADC_WIDTH + AVG_LOG2;
    localparam logic [15:0]     SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [AVG_LOG2:0] SAMP_ONE  = (AVG_LOG2+1)'(1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETTLE_H = 3'd1,
        ACC_H    = 3'd2,
        SETTLE_L = 3'd3,
        ACC_L    = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic p_s1, ps, ps_d;
    logic rise, fall;

    logic [15:0]          settle_cnt;
    logic [AVG_LOG2:0]    samp_cnt;
    logic [ACC_W-1:0]     acc;
    logic [ADC_WIDTH-1:0] plus_stage;
    logic [ADC_WIDTH-1:0] avg;
    logic                 done;

    logic settle_clr, settle_inc, acc_clr, acc_en, stage_en, out_en, err_set;

    assign rise = ps & ~ps_d;
    assign fall = ~ps & ps_d;
    // Floor average: dropping the low AVG_LOG2 bits is an arithmetic right shift.
    assign avg  = acc[ACC_W-1:AVG_LOG2];
    assign done = samp_cnt[AVG_LOG2];

    always_ff @(posedge adc_clk or negedge adc_rstn) begin
        if (!adc_rstn) begin
            p_s1 <= 1'b0;
            ps   <= 1'b0;
            ps_d <= 1'b0;
        end else begin
            p_s1 <= P;
            ps   <= p_s1;
            ps_d <= ps;
        end
    end

    always_ff @(posedge adc_clk or negedge adc_rstn) begin
        if (!adc_rstn) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        settle_clr = 1'b0;
        settle_inc = 1'b0;
        acc_clr    = 1'b0;
        acc_en     = 1'b0;
        stage_en   = 1'b0;
        out_en     = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt  = SETTLE_H;
                    settle_clr = 1'b1;
                end
            end
            SETTLE_H: begin
                if (fall) begin
                    err_set   = 1'b1;
                    state_nxt = IDLE;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = ACC_H;
                    acc_clr   = 1'b1;
                end else begin
                    settle_inc = 1'b1;
                end
            end
            ACC_H: begin
                if (fall) begin
                    if (done) begin
                        stage_en   = 1'b1;
                        settle_clr = 1'b1;
                        state_nxt  = SETTLE_L;
                    end else begin
                        err_set   = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (!done) begin
                    acc_en = 1'b1;
                end
            end
            SETTLE_L: begin
                if (rise) begin
                    err_set    = 1'b1;
                    settle_clr = 1'b1;
                    state_nxt  = SETTLE_H;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = ACC_L;
                    acc_clr   = 1'b1;
                end else begin
                    settle_inc = 1'b1;
                end
            end
            ACC_L: begin
                if (rise) begin
                    // A rise always starts a new plus phase; it only reports if the minus phase was complete.
                    out_en     = done;
                    err_set    = ~done;
                    settle_clr = 1'b1;
                    state_nxt  = SETTLE_H;
                end else if (!done) begin
                    acc_en = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge adc_clk or negedge adc_rstn) begin
        if (!adc_rstn) begin
            settle_cnt <= '0;
            samp_cnt   <= '0;
            acc        <= '0;
            plus_stage <= '0;
            j_plus     <= '0;
            j_minus    <= '0;
            dj         <= '0;
            valid      <= 1'b0;
            err        <= 1'b0;
        end else begin
            if (settle_clr)      settle_cnt <= '0;
            else if (settle_inc) settle_cnt <= settle_cnt + 16'd1;

            if (acc_clr) begin
                acc      <= '0;
                samp_cnt <= '0;
            end else if (acc_en) begin
                acc      <= acc + {{AVG_LOG2{adc_a[ADC_WIDTH-1]}}, adc_a};
                samp_cnt <= samp_cnt + SAMP_ONE;
            end

            if (stage_en) plus_stage <= avg;

            valid <= out_en;
            if (out_en) begin
                j_plus  <= plus_stage;
                j_minus <= avg;
                dj      <= {plus_stage[ADC_WIDTH-1], plus_stage} - {avg[ADC_WIDTH-1], avg};
            end

            // A new error wins over a simultaneous clear.
            if (err_set)      err <= 1'b1;
            else if (clr_err) err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pulse_adc_demod.sv
// Directed bench for pulse_adc_demod (SETTLE_CYCLES=4, AVG_LOG2=2); expected results are queued
// at stimulus time and checked by a separate monitor whenever valid is presented.
module tb_pulse_adc_demod;

    logic        adc_clk;
    logic        adc_rstn;
    logic        P;
    logic [13:0] adc_a;
    logic        clr_err;
    logic [13:0] j_plus;
    logic [13:0] j_minus;
    logic [14:0] dj;
    logic        valid;
    logic        err;

    typedef struct {
        int jp;
        int jm;
        int dj;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   hjp   = 0;
    int   hjm   = 0;
    int   hdj   = 0;

    pulse_adc_demod #(
        .ADC_WIDTH    (14),
        .SETTLE_CYCLES(4),
        .AVG_LOG2     (2)
    ) dut (
        .adc_clk (adc_clk),
        .adc_rstn(adc_rstn),
        .P       (P),
        .adc_a   (adc_a),
        .clr_err (clr_err),
        .j_plus  (j_plus),
        .j_minus (j_minus),
        .dj      (dj),
        .valid   (valid),
        .err     (err)
    );

    initial begin
        adc_clk = 1'b0;
        forever #5 adc_clk = ~adc_clk;
    end

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: pops on valid, otherwise outputs must hold the last reported (or reset) values.
    always @(negedge adc_clk) begin
        exp_t e;
        if (!adc_rstn) begin
            hjp = 0;
            hjm = 0;
            hdj = 0;
        end
        if (valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid actual=1 required=0 t=%0t", $time);
            end else begin
                e = sb.pop_front();
                check("j_plus", int'($signed(j_plus)), e.jp);
                check("j_minus", int'($signed(j_minus)), e.jm);
                check("dj", int'($signed(dj)), e.dj);
                hjp = e.jp;
                hjm = e.jm;
                hdj = e.dj;
            end
        end else begin
            check("hold_j_plus", int'($signed(j_plus)), hjp);
            check("hold_j_minus", int'($signed(j_minus)), hjm);
            check("hold_dj", int'($signed(dj)), hdj);
        end
    end

    // One P phase of len cycles. Edge n=3 is the edge cycle, n=4..7 settle, n=8..11 accumulate.
    task automatic phase(input logic pval, input int len, input int early,
                         input int s0, input int s1, input int s2, input int s3,
                         input int late, input bit exp_v,
                         input int ejp, input int ejm, input int edj, input int clr_n);
        int s[4];
        int v;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        if (exp_v) sb.push_back('{jp: ejp, jm: ejm, dj: edj});
        P = pval;
        for (int n = 1; n <= len; n++) begin
            if (n <= 7)       v = early;
            else if (n <= 11) v = s[n-8];
            else              v = late;
            adc_a   = v[13:0];
            clr_err = (n == clr_n);
            @(posedge adc_clk);
            #1;
            if (exp_v && n == 2) check("latency_n2_valid", int'(valid), 0);
            if (exp_v && n == 3) check("latency_n3_valid", int'(valid), 1);
            if (clr_n != 0 && n == clr_n) check("err_set_with_clr", int'(err), 1);
        end
        clr_err = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        adc_rstn = 1'b1;
        P        = 1'b0;
        adc_a    = '0;
        clr_err  = 1'b0;
        #1 adc_rstn = 1'b0;
        repeat (3) @(posedge adc_clk);
        #1;
        check("rst_valid", int'(valid), 0);
        check("rst_err", int'(err), 0);
        check("rst_dj", int'($signed(dj)), 0);
        adc_rstn = 1'b1;
        repeat (2) @(posedge adc_clk);
        #1;

        // Basic period, floor of negatives, settle exclusion, full-scale, positive/negative floors.
        phase(1, 20, 100, 100, 100, 100, 100, 100, 0, 0, 0, 0, 0);
        phase(0, 20, -50, -50, -50, -50, -50, -50, 0, 0, 0, 0, 0);
        phase(1, 20, 7, -1, -1, -1, -2, 7, 1, 100, -50, 150, 0);
        phase(0, 20, 0, 3, 3, 3, 3, 0, 0, 0, 0, 0, 0);
        phase(1, 20, 8191, 10, 10, 10, 10, -8000, 1, -2, 3, -5, 0);
        phase(0, 20, 0, -8192, -8192, -8192, -8192, 0, 0, 0, 0, 0, 0);
        phase(1, 20, 0, 8191, 8191, 8191, 8191, 0, 1, 10, -8192, 8202, 0);
        phase(0, 20, 0, -8192, -8192, -8192, -8192, 0, 0, 0, 0, 0, 0);
        phase(1, 20, 0, 5, 6, 6, 6, 0, 1, 8191, -8192, 16383, 0);
        phase(0, 20, 0, -7, -6, -6, -6, 0, 0, 0, 0, 0, 0);

        // Short plus phase: still reports the previous period, then errors on its fall.
        phase(1, 5, 1, 1, 1, 1, 1, 1, 1, 5, -7, 12, 0);
        check("err_before_short", int'(err), 0);
        phase(0, 20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        check("err_sticky", int'(err), 1);
        clr_err = 1'b1;
        @(posedge adc_clk);
        #1;
        clr_err = 1'b0;
        check("err_cleared", int'(err), 0);

        // Recovery from IDLE: first rise reports nothing, next full period reports.
        phase(1, 20, 0, 40, 40, 40, 40, 0, 0, 0, 0, 0, 0);
        phase(0, 20, 0, 20, 20, 20, 20, 0, 0, 0, 0, 0, 0);
        phase(1, 20, 0, 0, 0, 0, 0, 0, 1, 40, 20, 20, 0);

        // Reset mid ACC_L, released with P already high.
        P     = 1'b0;
        adc_a = 14'd33;
        repeat (9) @(posedge adc_clk);
        #1;
        adc_rstn = 1'b0;
        #1;
        check("midrst_j_plus", int'($signed(j_plus)), 0);
        check("midrst_j_minus", int'($signed(j_minus)), 0);
        check("midrst_dj", int'($signed(dj)), 0);
        check("midrst_valid", int'(valid), 0);
        P = 1'b1;
        repeat (3) @(posedge adc_clk);
        #1;
        adc_rstn = 1'b1;
        phase(1, 20, 0, 60, 60, 60, 60, 0, 0, 0, 0, 0, 0);
        phase(0, 20, 0, -60, -60, -60, -60, 0, 0, 0, 0, 0, 0);
        phase(1, 20, 0, 0, 0, 0, 0, 0, 1, 60, -60, 120, 0);
        phase(0, 20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        repeat (10) @(posedge adc_clk);
        #1;
        check("scoreboard_empty", sb.size(), 0);
        check("final_err", int'(err), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
